// File: rtl/clk_div_checker.sv
// clk_div_checker: samples a divided clock as data in the clk domain,
// measures high/low/period in clk cycles, tracks lock against the expected
// divisor and flags duty, period and stuck faults.
// Optional macro CLK_DIV_CHECKER_SYNC_EN adds a 2-flop synchronizer on div_in
// for asynchronous divided clocks (+2 cycles latency).
module clk_div_checker #(
    parameter int EXP_DIV  = 10,
    parameter int TOL      = 0,
    parameter int CNT_W    = 8,
    parameter int TIMEOUT  = 2 * EXP_DIV,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_in,
    input  logic             err_clr,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic [CNT_W:0]   period,
    output logic             meas_valid,
    output logic             locked,
    output logic             stuck,
    output logic             err
);

    localparam int EXP_H = EXP_DIV / 2;
    localparam int EXP_L = EXP_DIV - EXP_H;
    localparam int GC_W  = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [GC_W-1:0]  LOCK_V  = GC_W'(LOCK_CNT);

    // The counter must be able to reach TIMEOUT, otherwise stuck never fires.
    if (TIMEOUT > (2 ** CNT_W) - 1) begin : g_width_check
        $error("clk_div_checker: CNT_W too small for TIMEOUT");
    end

    typedef enum logic [1:0] {
        S_WAIT_RISE = 2'd0,
        S_HIGH      = 2'd1,
        S_LOW       = 2'd2
    } state_t;

    state_t          state;
    logic            div_src;
    logic            div_s;
    logic            div_d;
    logic            rise;
    logic            fall;
    logic            edge_det;
    logic [CNT_W-1:0] cnt;
    logic [GC_W-1:0] good_cnt;
    logic            to_evt;
    logic            bad_high;
    logic            period_done;
    logic            good_per;
    logic            err_evt;

    // Signed comparison so short levels cannot underflow the deviation.
    function automatic logic in_tol(input logic [CNT_W-1:0] v, input int exp_v);
        int d;
        d = int'(v) - exp_v;
        return (d <= TOL) && (d >= -TOL);
    endfunction

`ifdef CLK_DIV_CHECKER_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer for a divided clock that is asynchronous to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], div_in};
    end

    assign div_src = sync_q[1];
`else
    assign div_src = div_in;
`endif

    // Sample and edge-detect flops run regardless of en, so re-enable sees no false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_s <= 1'b0;
            div_d <= 1'b0;
        end else begin
            div_s <= div_src;
            div_d <= div_s;
        end
    end

    // Edge qualification and the error events for this cycle.
    always_comb begin
        rise        = div_s & ~div_d;
        fall        = ~div_s & div_d;
        edge_det    = rise | fall;
        to_evt      = en && (cnt == TO_VAL) && !edge_det;
        bad_high    = en && !to_evt && (state == S_HIGH) && fall && !in_tol(cnt, EXP_H);
        period_done = en && !to_evt && (state == S_LOW) && rise;
        good_per    = period_done && in_tol(high_time, EXP_H) && in_tol(cnt, EXP_L);
        err_evt     = to_evt | bad_high | (period_done & ~good_per);
    end

    // Level-duration counter: reloads to 1 on an edge, saturates, idles at 0 when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             cnt <= '0;
        else if (!en)        cnt <= '0;
        else if (edge_det)   cnt <= CNT_W'(1);
        else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end

    // Measurement FSM with lock tracking, stuck detection and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_WAIT_RISE;
            high_time  <= '0;
            low_time   <= '0;
            period     <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            stuck      <= 1'b0;
            good_cnt   <= '0;
        end else begin
            meas_valid <= 1'b0;
            if (!en) begin
                state    <= S_WAIT_RISE;
                good_cnt <= '0;
                locked   <= 1'b0;
                stuck    <= 1'b0;
            end else if (to_evt) begin
                stuck    <= 1'b1;
                locked   <= 1'b0;
                good_cnt <= '0;
                state    <= S_WAIT_RISE;
            end else begin
                if (edge_det) stuck <= 1'b0;
                case (state)
                    S_WAIT_RISE: begin
                        if (rise) state <= S_HIGH;
                    end
                    S_HIGH: begin
                        if (fall) begin
                            high_time <= cnt;
                            state     <= S_LOW;
                            // A bad high time drops lock as soon as it is reported.
                            if (!in_tol(cnt, EXP_H)) begin
                                good_cnt <= '0;
                                locked   <= 1'b0;
                            end
                        end
                    end
                    S_LOW: begin
                        if (rise) begin
                            low_time   <= cnt;
                            period     <= {1'b0, high_time} + {1'b0, cnt};
                            meas_valid <= 1'b1;
                            state      <= S_HIGH;
                            if (good_per) begin
                                if (good_cnt != LOCK_V) begin
                                    good_cnt <= good_cnt + 1'b1;
                                    locked   <= (good_cnt == LOCK_V - 1'b1);
                                end
                            end else begin
                                good_cnt <= '0;
                                locked   <= 1'b0;
                            end
                        end
                    end
                    default: state <= S_WAIT_RISE;
                endcase
            end
        end
    end

    // Sticky error; a new error event outranks a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          err <= 1'b0;
        else if (err_evt) err <= 1'b1;
        else if (err_clr) err <= 1'b0;
    end

endmodule
